// File: rtl/convolution_pipeline_stream.sv
// rtl/convolution_pipeline_stream.sv - NxN streaming convolution with normalisation shift, rounding and clamp
// Global-stall pipeline: input regs, products, registered adder tree, round/shift/clamp output stage.
module convolution_pipeline_stream #(
  parameter int C_SIGNAL_WIDTH     = 12,
  parameter int C_KERNEL_DIMENSION = 3,
  parameter int C_KERNEL_WIDTH     = 13,
  parameter int C_SHIFT_WIDTH      = 4
) (
  input  logic                                                            clk,
  input  logic                                                            rst,
  input  logic                                                            in_valid,
  output logic                                                            in_ready,
  input  logic [C_KERNEL_DIMENSION*C_KERNEL_DIMENSION*C_SIGNAL_WIDTH-1:0] window_input,
  input  logic [C_KERNEL_DIMENSION*C_KERNEL_DIMENSION*C_KERNEL_WIDTH-1:0] filter,
  input  logic [C_SHIFT_WIDTH-1:0]                                        shift,
  input  logic                                                            round_en,
  output logic                                                            out_valid,
  input  logic                                                            out_ready,
  output logic [C_SIGNAL_WIDTH-1:0]                                       output_pixel,
  output logic                                                            sat_flag
);
  localparam int SW = C_SIGNAL_WIDTH;
  localparam int KW = C_KERNEL_WIDTH;
  localparam int HW = C_SHIFT_WIDTH;
  localparam int NT = C_KERNEL_DIMENSION * C_KERNEL_DIMENSION;
  localparam int T  = $clog2(NT);
  localparam int P  = SW + KW + 1;
  localparam int A  = P + T;
  // Rounding addend can reach 2^(2^HW-2), so the rounded sum needs room for it as well as the sum.
  localparam int R  = ((A > (1 << HW)) ? A : (1 << HW)) + 1;
  localparam logic [HW-1:0] SH_ONE = 1;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic [NT*SW-1:0] win_r;
  logic [NT*KW-1:0] filt_r;
  logic [HW-1:0]    sh_r;
  logic             rnd_r;
  logic             vld_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         vld_r <= 1'b0;
    else if (advance) vld_r <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      win_r  <= window_input;
      filt_r <= filter;
      sh_r   <= shift;
      rnd_r  <= round_en;
    end
  end

  // Level 0 holds the products, level T the single accumulated sum.
  genvar l, i;
  for (l = 0; l <= T; l++) begin : g_lvl
    localparam int CNT = (NT + (1 << l) - 1) >> l;
    logic signed [A-1:0] node_d [CNT];
    logic signed [A-1:0] node   [CNT];
    logic [HW-1:0]       sh_d, sh;
    logic                rnd_d, rnd, vld_d, vld;

    if (l == 0) begin : g_leaf
      assign sh_d  = sh_r;
      assign rnd_d = rnd_r;
      assign vld_d = vld_r;
      for (i = 0; i < CNT; i++) begin : g_mul
        logic signed [P-1:0] px, cf, prod;
        assign px        = {{(P-SW){1'b0}}, win_r[i*SW +: SW]};
        assign cf        = {{(P-KW){filt_r[i*KW+KW-1]}}, filt_r[i*KW +: KW]};
        assign prod      = px * cf;
        assign node_d[i] = {{T{prod[P-1]}}, prod};
      end
    end else begin : g_add
      localparam int PCNT = (NT + (1 << (l-1)) - 1) >> (l-1);
      assign sh_d  = g_lvl[l-1].sh;
      assign rnd_d = g_lvl[l-1].rnd;
      assign vld_d = g_lvl[l-1].vld;
      for (i = 0; i < CNT; i++) begin : g_node
        if (2*i+1 < PCNT) begin : g_pair
          assign node_d[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
        end else begin : g_pass
          assign node_d[i] = g_lvl[l-1].node[2*i];
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)         vld <= 1'b0;
      else if (advance) vld <= vld_d;
    end

    always_ff @(posedge clk) begin
      if (advance) begin
        sh  <= sh_d;
        rnd <= rnd_d;
        for (int k = 0; k < CNT; k++) node[k] <= node_d[k];
      end
    end
  end

  logic signed [R-1:0] rsum, shifted;
  logic [SW-1:0]       pix_d;
  logic                sat_d;

  always_comb begin
    rsum = {{(R-A){g_lvl[T].node[0][A-1]}}, g_lvl[T].node[0]};
    if (g_lvl[T].rnd && (g_lvl[T].sh != '0))
      rsum = rsum + ({{(R-1){1'b0}}, 1'b1} << (g_lvl[T].sh - SH_ONE));
    shifted = rsum >>> g_lvl[T].sh;
    pix_d   = shifted[SW-1:0];
    sat_d   = 1'b0;
    if (shifted[R-1]) begin
      pix_d = '0;
      sat_d = 1'b1;
    end else if (|shifted[R-2:SW]) begin
      pix_d = '1;
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      output_pixel <= '0;
      sat_flag     <= 1'b0;
    end else if (advance) begin
      out_valid    <= g_lvl[T].vld;
      output_pixel <= pix_d;
      sat_flag     <= sat_d;
    end
  end
endmodule

// File: tb/tb_convolution_pipeline_stream.sv
// tb/tb_convolution_pipeline_stream.sv - directed bench for convolution_pipeline_stream (N=3 and N=5 instances)
module tb_convolution_pipeline_stream;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid3, in_ready3, round3, out_valid3, out_ready3, sat3;
  logic [107:0] win3;
  logic [116:0] filt3;
  logic [3:0]   shift3;
  logic [11:0]  pix3;

  logic         in_valid5, in_ready5, out_valid5, sat5;
  logic [299:0] win5;
  logic [324:0] filt5;
  logic [11:0]  pix5;

  int tests = 0;
  int fails = 0;

  convolution_pipeline_stream dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .window_input(win3), .filter(filt3), .shift(shift3), .round_en(round3),
    .out_valid(out_valid3), .out_ready(out_ready3), .output_pixel(pix3), .sat_flag(sat3)
  );

  convolution_pipeline_stream #(.C_KERNEL_DIMENSION(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
    .window_input(win5), .filter(filt5), .shift(4'd0), .round_en(1'b0),
    .out_valid(out_valid5), .out_ready(1'b1), .output_pixel(pix5), .sat_flag(sat5)
  );

  task automatic set3_window_const(input int val);
    for (int i = 0; i < 9; i++) win3[i*12 +: 12] = 12'(val);
  endtask

  task automatic set3_filter_identity();
    filt3 = '0;
    filt3[4*13 +: 13] = 13'd1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid3 = 1'b0; round3 = 1'b0; shift3 = '0; out_ready3 = 1'b1;
    win3 = '0; filt3 = '0; in_valid5 = 1'b0; win5 = '0; filt5 = '0;
    repeat (3) @(negedge clk);
    tests++; if (out_valid3 !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid3); end
    tests++; if (pix3 !== 12'd0) begin fails++; $display("FAIL reset_pixel: got %0d want 0", pix3); end
    tests++; if (sat3 !== 1'b0) begin fails++; $display("FAIL reset_sat: got %b want 0", sat3); end
    tests++; if (out_valid5 !== 1'b0) begin fails++; $display("FAIL reset_out_valid5: got %b want 0", out_valid5); end
    rst = 1'b1;
    @(negedge clk);
    tests++; if (in_ready3 !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready3); end
  endtask

  task automatic test_identity_latency(input int val);
    int cyc;
    set3_window_const(val); set3_filter_identity(); shift3 = 4'd0; round3 = 1'b0;
    out_ready3 = 1'b1; in_valid3 = 1'b1;
    @(negedge clk);
    in_valid3 = 1'b0; cyc = 1;
    while (!out_valid3 && cyc < 20) begin @(negedge clk); cyc++; end
    tests++; if (cyc != 7) begin fails++; $display("FAIL latency3: got %0d cycles want 7", cyc); end
    tests++; if (pix3 !== 12'(val)) begin fails++; $display("FAIL identity_pixel: got %0d want %0d", pix3, val); end
    tests++; if (sat3 !== 1'b0) begin fails++; $display("FAIL identity_sat: got %b want 0", sat3); end
    @(negedge clk);
    tests++; if (out_valid3 !== 1'b0) begin fails++; $display("FAIL identity_single: out_valid %b want 0", out_valid3); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    shift3 = 4'd0; round3 = 1'b0; out_ready3 = 1'b1;
    set3_window_const(10);
    filt3 = '0;
    for (int i = 0; i < 9; i += 4) filt3[i*13 +: 13] = 13'h1FFF;
    in_valid3 = 1'b1;
    @(negedge clk);
    set3_window_const(4095);
    filt3 = '0;
    for (int i = 0; i < 9; i += 4) filt3[i*13 +: 13] = 13'd1;
    @(negedge clk);
    in_valid3 = 1'b0; cyc = 2;
    while (!out_valid3 && cyc < 20) begin @(negedge clk); cyc++; end
    tests++; if (cyc != 7) begin fails++; $display("FAIL b2b_latency: got %0d want 7", cyc); end
    tests++; if (pix3 !== 12'd0 || sat3 !== 1'b1) begin fails++; $display("FAIL b2b_low: got %0d/%b want 0/1", pix3, sat3); end
    @(negedge clk);
    tests++; if (out_valid3 !== 1'b1 || pix3 !== 12'd4095 || sat3 !== 1'b1) begin
      fails++; $display("FAIL b2b_high: got v%b %0d/%b want v1 4095/1", out_valid3, pix3, sat3); end
    @(negedge clk);
    tests++; if (out_valid3 !== 1'b0) begin fails++; $display("FAIL b2b_end: out_valid %b want 0", out_valid3); end
  endtask

  task automatic test_round_shift();
    int cyc;
    logic [3:0]  sh_v  [3];
    logic        rn_v  [3];
    logic [11:0] exp_v [3];
    sh_v[0] = 4'd3; rn_v[0] = 1'b0; exp_v[0] = 12'd5;
    sh_v[1] = 4'd3; rn_v[1] = 1'b1; exp_v[1] = 12'd6;
    sh_v[2] = 4'd0; rn_v[2] = 1'b1; exp_v[2] = 12'd45;
    for (int i = 0; i < 9; i++) begin
      win3[i*12 +: 12] = 12'(i + 1);
      filt3[i*13 +: 13] = 13'd1;
    end
    out_ready3 = 1'b1;
    for (int j = 0; j < 3; j++) begin
      shift3 = sh_v[j]; round3 = rn_v[j]; in_valid3 = 1'b1;
      @(negedge clk);
    end
    in_valid3 = 1'b0; shift3 = 4'd0; round3 = 1'b0; cyc = 3;
    while (!out_valid3 && cyc < 20) begin @(negedge clk); cyc++; end
    for (int j = 0; j < 3; j++) begin
      tests++; if (out_valid3 !== 1'b1 || pix3 !== exp_v[j] || sat3 !== 1'b0) begin
        fails++; $display("FAIL round_%0d: got v%b %0d/%b want v1 %0d/0", j, out_valid3, pix3, sat3, exp_v[j]); end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    int sent, got;
    logic [11:0] prev_pix;
    logic prev_stall;
    sent = 0; got = 0; prev_pix = '0; prev_stall = 1'b0;
    set3_filter_identity(); shift3 = 4'd0; round3 = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      out_ready3 = !(cyc >= 10 && cyc < 13);
      if (sent < 10) begin in_valid3 = 1'b1; set3_window_const(sent + 1); end
      else in_valid3 = 1'b0;
      #1;
      if (out_valid3 && !out_ready3) begin
        tests++; if (in_ready3 !== 1'b0) begin fails++; $display("FAIL stall_in_ready: got %b want 0 at cycle %0d", in_ready3, cyc); end
        if (prev_stall) begin
          tests++; if (pix3 !== prev_pix) begin fails++; $display("FAIL stall_hold: got %0d want %0d", pix3, prev_pix); end
        end
      end
      prev_stall = out_valid3 && !out_ready3;
      prev_pix = pix3;
      if (out_valid3 && out_ready3) begin
        tests++; if (pix3 !== 12'(got + 1)) begin fails++; $display("FAIL stream_order: got %0d want %0d", pix3, got + 1); end
        got++;
      end
      if (in_valid3 && in_ready3) sent++;
      @(negedge clk);
    end
    in_valid3 = 1'b0; out_ready3 = 1'b1;
    tests++; if (got != 10) begin fails++; $display("FAIL stream_count: got %0d want 10", got); end
    tests++; if (out_valid3 !== 1'b0) begin fails++; $display("FAIL stream_extra: out_valid %b want 0", out_valid3); end
  endtask

  task automatic test_reset_midstream();
    int stale;
    set3_filter_identity(); set3_window_const(7); shift3 = 4'd0; round3 = 1'b0;
    out_ready3 = 1'b0; in_valid3 = 1'b1;
    repeat (4) @(negedge clk);
    in_valid3 = 1'b0;
    repeat (6) @(negedge clk);
    tests++; if (out_valid3 !== 1'b1 || pix3 !== 12'd7) begin
      fails++; $display("FAIL midrst_pre: got v%b %0d want v1 7", out_valid3, pix3); end
    #2 rst = 1'b0;
    #1;
    tests++; if (out_valid3 !== 1'b0 || pix3 !== 12'd0 || sat3 !== 1'b0) begin
      fails++; $display("FAIL midrst_async: got v%b %0d/%b want v0 0/0", out_valid3, pix3, sat3); end
    @(negedge clk);
    rst = 1'b1; out_ready3 = 1'b1; stale = 0;
    repeat (12) begin @(negedge clk); if (out_valid3) stale++; end
    tests++; if (stale != 0) begin fails++; $display("FAIL midrst_stale: got %0d outputs want 0", stale); end
    test_identity_latency(9);
  endtask

  task automatic test_n5();
    int cyc;
    logic [12:0] coef_v [2];
    logic [11:0] exp_pix [2];
    logic        exp_sat [2];
    coef_v[0] = 13'd1;    exp_pix[0] = 12'd2500; exp_sat[0] = 1'b0;
    coef_v[1] = 13'h1000; exp_pix[1] = 12'd0;    exp_sat[1] = 1'b1;
    for (int i = 0; i < 25; i++) win5[i*12 +: 12] = 12'd100;
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 25; i++) filt5[i*13 +: 13] = coef_v[j];
      in_valid5 = 1'b1;
      @(negedge clk);
      in_valid5 = 1'b0; cyc = 1;
      while (!out_valid5 && cyc < 20) begin @(negedge clk); cyc++; end
      tests++; if (cyc != 8) begin fails++; $display("FAIL n5_latency_%0d: got %0d want 8", j, cyc); end
      tests++; if (pix5 !== exp_pix[j] || sat5 !== exp_sat[j]) begin
        fails++; $display("FAIL n5_result_%0d: got %0d/%b want %0d/%b", j, pix5, sat5, exp_pix[j], exp_sat[j]); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_identity_latency(12);
    test_back_to_back();
    test_round_shift();
    test_stall();
    test_reset_midstream();
    test_n5();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/convolution_pipeline_stream.md
Name: convolution_pipeline_stream

Overview:
- Parametrised successor to the fixed 3x3 convolution pipeline: NxN window of unsigned pixels convolved with an NxN signed kernel.
- Adds valid/ready streaming with backpressure, a per-window programmable normalisation shift with optional rounding, and a saturation flag.
- Sits between the line-buffer/window generator and the output pixel writer in the image filter chain.

Parameters:
- C_SIGNAL_WIDTH, 12, pixel width (unsigned) for input and output.
- C_KERNEL_DIMENSION, 3, kernel/window side N (N >= 2); N*N taps.
- C_KERNEL_WIDTH, 13, signed coefficient width.
- C_SHIFT_WIDTH, 4, width of the normalisation shift field.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  window/filter/shift/round_en valid.
- in_ready  out  1  block can accept a window this cycle.
- window_input  in  N*N*C_SIGNAL_WIDTH  flattened window, row-major, tap [0][0] in LSBs.
- filter  in  N*N*C_KERNEL_WIDTH  flattened signed kernel, same ordering.
- shift  in  C_SHIFT_WIDTH  arithmetic right shift applied to the sum.
- round_en  in  1  round half-up before shifting.
- out_valid  out  1  output_pixel valid.
- out_ready  in  1  downstream accepts output.
- output_pixel  out  C_SIGNAL_WIDTH  clamped result.
- sat_flag  out  1  result was clamped (low or high); qualified by out_valid.

Behaviour:
- Reset (rst=0, async): every stage valid bit, out_valid, output_pixel and sat_flag go to 0 immediately. In-flight windows are discarded. in_ready reads 1 once rst is deasserted.
- Global stall: advance = !out_valid || out_ready. in_ready = advance.
  - Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
  - When advance=0, every pipeline register including valids holds.
  - Bubbles are not collapsed.
- Stages:
  - S0: register window, filter, shift, round_en.
  - S1: N*N products; pixel zero-extended to signed; product width P = C_SIGNAL_WIDTH+C_KERNEL_WIDTH+1.
  - S2..S(1+T): registered binary adder tree, T = ceil(log2(N*N)) levels. Odd operand passes through a level registered. Accumulator width A = P+T, no overflow possible.
  - Final stage: round, shift, clamp into output registers.
- Latency: L = 3+T cycles from input transfer to out_valid with no stall (N=3: 7; N=5: 8). Throughput: 1 window/cycle when out_ready=1.
- Round/shift:
  - If round_en=1 and shift>0, add 2^(shift-1) to the sum.
  - Then arithmetic right shift by shift. shift=0 means no shift and no rounding.
  - shift and round_en travel with their window; a new value applies only to the window it accompanied.
- Clamp:
  - Result < 0 gives 0 with sat_flag=1.
  - Result > 2^C_SIGNAL_WIDTH-1 gives all-ones with sat_flag=1.
  - Otherwise the low C_SIGNAL_WIDTH bits with sat_flag=0.
- Output stability: while out_valid=1 and out_ready=0, output_pixel and sat_flag hold constant.
- Simultaneous output transfer and input accept in the same cycle is legal; no data is lost or duplicated.
- Inputs are ignored when in_valid=0 or in_ready=0.

Test Plan:
- Reset release; all taps 12, identity kernel (centre 1), shift 0; in_valid one cycle, out_ready=1 -> out_valid exactly 7 cycles later, output_pixel=12, sat_flag=0.
- Back-to-back windows: all 10s with diagonal -1, then all 4095 with diagonal +1 -> consecutive outputs 0 (sat_flag=1) then 4095 (sat_flag=1), on consecutive cycles.
- Window values 1..9, all-ones kernel (sum 45), shift=3: round_en=0 -> 5; round_en=1 -> 6. shift=0 -> 45.
- Stream 10 windows with pixel value k (k=1..10), identity kernel, holding out_ready=0 for 3 cycles mid-stream:
  - outputs are 1..10 in order, none dropped or duplicated;
  - in_ready=0 while stalled;
  - output_pixel stable during the stall.
- Assert rst low mid-stream with 4 windows in flight -> out_valid and output_pixel 0 asynchronously. After release, no stale outputs appear; the next window returns its correct result after L cycles.
- Instance N=5, all taps 100, all coefficients 1, shift 0 -> 2500 after 8 cycles. All coefficients -4096 (min signed) -> 0 with sat_flag=1.
